// File: rtl/dm_pkg.sv
// dm_pkg: shared state encoding, default geometry and log2 helper for the banked data memory
package dm_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEF_LINE_W  = 256;
  localparam int DEF_DEPTH   = 512;
  localparam int DEF_LATENCY = 6;
  localparam int DEF_ADDR_W  = 32;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/dm_line_ram.sv
// dm_line_ram: single-port line RAM with per-byte write enables and a registered, clearable read port
module dm_line_ram #(
  parameter int LINE_W = 256,
  parameter int DEPTH  = 512,
  parameter int IDX    = 9
)(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                we_i,
  input  logic                clr_i,
  input  logic [LINE_W/8-1:0] be_i,
  input  logic [IDX-1:0]      idx_i,
  input  logic [LINE_W-1:0]   wdata_i,
  output logic [LINE_W-1:0]   rdata_o
);
  logic [LINE_W-1:0] r_mem [DEPTH];
  logic [LINE_W-1:0] r_rdata;
  assign rdata_o = r_rdata;
  // byte-masked write; storage itself is never reset
  always_ff @(posedge clk_i) begin
    if (en_i && we_i)
      for (int k = 0; k < LINE_W/8; k++)
        if (be_i[k]) r_mem[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
  end
  // read register holds its value until the next read access; clr forces an all-zero line
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rdata <= '0;
    else if (en_i && !we_i) r_rdata <= clr_i ? '0 : r_mem[idx_i];
  end
endmodule

// File: rtl/data_memory_banked.sv
// data_memory_banked: parametrised line memory with enable/ack handshake, fixed latency and range check
module data_memory_banked
  import dm_pkg::*;
#(
  parameter int LINE_W  = DEF_LINE_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int ADDR_W  = DEF_ADDR_W
)(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                write_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [LINE_W-1:0]   data_i,
  input  logic [LINE_W/8-1:0] be_i,
  output logic                ack_o,
  output logic [LINE_W-1:0]   data_o,
  output logic                busy_o,
  output logic                err_o
);
  localparam int BE_W = LINE_W / 8;
  localparam int OFF  = clog2(BE_W);
  localparam int IDX  = clog2(DEPTH);
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_memory_banked: LATENCY must be within 1..15");
  end
  state_t            r_state, w_next;
  logic [3:0]        r_count;
  logic              r_wr, r_oor, r_ack, r_err;
  logic [IDX-1:0]    r_idx;
  logic [LINE_W-1:0] r_data;
  logic [BE_W-1:0]   r_be;
  logic              w_accept, w_access, w_unused;
  assign w_accept = (r_state == IDLE) && enable_i;
  assign w_access = (r_state == WAIT) && (r_count == 4'(LATENCY - 1));
  assign w_unused = ^addr_i[OFF-1:0];
  assign ack_o    = r_ack;
  assign err_o    = r_err;
  assign busy_o   = r_state != IDLE;
  // next state: accept in IDLE, count out the latency in WAIT, single response cycle
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (enable_i ? WAIT : IDLE) :
             (r_state == WAIT) ? (w_access ? RESP : WAIT) : IDLE;
  end
  // state, latency counter and registered response flags
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= (r_state == WAIT) ? r_count + 4'd1 : 4'd0;
      r_ack   <= w_access;
      r_err   <= w_access && r_oor;
    end
  end
  // request capture; an abandoned request is harmless because the access only fires from WAIT
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr   <= 1'b0;
      r_oor  <= 1'b0;
      r_idx  <= '0;
      r_data <= '0;
      r_be   <= '0;
    end else if (w_accept) begin
      r_wr   <= write_i;
      r_oor  <= |addr_i[ADDR_W-1:OFF+IDX];
      r_idx  <= addr_i[OFF+IDX-1:OFF];
      r_data <= data_i;
      r_be   <= be_i;
    end
  end
  dm_line_ram #(.LINE_W(LINE_W), .DEPTH(DEPTH), .IDX(IDX)) u_ram (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .en_i    (w_access),
    .we_i    (r_wr && !r_oor),
    .clr_i   (r_oor),
    .be_i    (r_be),
    .idx_i   (r_idx),
    .wdata_i (r_data),
    .rdata_o (data_o)
  );
endmodule

// File: tb/tb_data_memory_banked.sv
// tb_data_memory_banked: directed checks of handshake, latency, masking, range errors and mid-op reset
module tb_data_memory_banked;
  localparam int LW = 256;
  localparam int BW = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          rst_n [3];
  logic          en    [3];
  logic          wr    [3];
  logic [31:0]   addr  [3];
  logic [LW-1:0] din   [3];
  logic [BW-1:0] be    [3];
  logic          ack   [3];
  logic          busy  [3];
  logic          err   [3];
  logic [LW-1:0] dout  [3];
  int n_cmp = 0;
  int n_bad = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_banked #(.LATENCY(g == 0 ? 6 : g == 1 ? 1 : 15)) u_dut (
      .clk_i    (clk),
      .rst_i    (rst_n[g]),
      .enable_i (en[g]),
      .write_i  (wr[g]),
      .addr_i   (addr[g]),
      .data_i   (din[g]),
      .be_i     (be[g]),
      .ack_o    (ack[g]),
      .data_o   (dout[g]),
      .busy_o   (busy[g]),
      .err_o    (err[g])
    );
  end
  function automatic int lat_of(input int s);
    return s == 0 ? 6 : s == 1 ? 1 : 15;
  endfunction
  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic req(input int s, input string tag, input logic w, input logic [31:0] a,
                     input logic [LW-1:0] d, input logic [BW-1:0] b,
                     output logic [LW-1:0] q, output logic e);
    int k;
    @(negedge clk);
    en[s] = 1'b1; wr[s] = w; addr[s] = a; din[s] = d; be[s] = b;
    @(posedge clk);
    @(negedge clk);
    en[s] = 1'b0;
    k = 0;
    while (!ack[s] && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"}, LW'(k), LW'(lat_of(s)));
    q = dout[s];
    e = err[s];
    @(negedge clk);
    chk({tag, "_ackw"}, LW'(ack[s]), '0);
  endtask
  initial begin
    logic [LW-1:0] q;
    logic e;
    int t [3];
    int c, n;
    for (int s = 0; s < 3; s++) begin
      rst_n[s] = 1'b0; en[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; din[s] = '0; be[s] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) rst_n[s] = 1'b1;
    @(negedge clk);
    chk("rst_ack", LW'(ack[0]), '0);
    chk("rst_busy", LW'(busy[0]), '0);
    chk("rst_err", LW'(err[0]), '0);
    chk("rst_data", dout[0], '0);
    repeat (3) @(negedge clk);
    chk("idle_busy", LW'(busy[0]), '0);
    req(0, "wr40", 1'b1, 32'h40, {32{8'hA5}}, '1, q, e);
    chk("wr40_err", LW'(e), '0);
    req(0, "rd40", 1'b0, 32'h40, '0, '0, q, e);
    chk("rd40_data", q, {32{8'hA5}});
    chk("rd40_err", LW'(e), '0);
    req(0, "mask", 1'b1, 32'h40, {32{8'hFF}}, 32'h0000_000F, q, e);
    chk("mask_hold", q, {32{8'hA5}});
    req(0, "rdm", 1'b0, 32'h40, '0, '0, q, e);
    chk("rdm_data", q, {{28{8'hA5}}, {4{8'hFF}}});
    req(0, "wr0", 1'b1, 32'h0, {32{8'h33}}, '1, q, e);
    req(0, "oor_rd", 1'b0, 32'h0001_0000, '0, '0, q, e);
    chk("oor_rd_err", LW'(e), LW'(1));
    chk("oor_rd_data", q, '0);
    req(0, "oor_wr", 1'b1, 32'h0001_0000, {32{8'h11}}, '1, q, e);
    chk("oor_wr_err", LW'(e), LW'(1));
    req(0, "rd0", 1'b0, 32'h0, '0, '0, q, e);
    chk("rd0_data", q, {32{8'h33}});
    chk("rd0_err", LW'(e), '0);
    @(negedge clk);
    en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h40;
    c = 0; n = 0;
    while (n < 3 && c < 100) begin
      @(negedge clk);
      c++;
      if (ack[0]) begin
        t[n] = c;
        n++;
      end
    end
    en[0] = 1'b0;
    chk("hold_n", LW'(n), LW'(3));
    chk("hold_gap1", LW'(t[1] - t[0]), LW'(8));
    chk("hold_gap2", LW'(t[2] - t[1]), LW'(8));
    repeat (2) @(negedge clk);
    chk("hold_idle", LW'(busy[0]), '0);
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    chk("pulse_busy", LW'(busy[0]), LW'(1));
    repeat (2) @(negedge clk);
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (ack[0]) n++;
    end
    chk("pulse_acks", LW'(n), LW'(1));
    for (int s = 0; s < 3; s++) begin
      string p;
      p = $sformatf("mid%0d", lat_of(s));
      req(s, {p, "_old"}, 1'b1, 32'hA0, {32{8'h3C}}, '1, q, e);
      @(negedge clk);
      en[s] = 1'b1; wr[s] = 1'b1; addr[s] = 32'hA0; din[s] = {32{8'hC3}}; be[s] = '1;
      @(posedge clk);
      repeat ((lat_of(s) - 1 < 3 ? lat_of(s) - 1 : 3) + 1) @(negedge clk);
      chk({p, "_inflight"}, LW'(busy[s]), LW'(1));
      rst_n[s] = 1'b0;
      en[s] = 1'b0;
      #1;
      chk({p, "_rstbusy"}, LW'(busy[s]), '0);
      repeat (2) @(negedge clk);
      rst_n[s] = 1'b1;
      n = 0;
      repeat (20) begin
        @(negedge clk);
        if (ack[s]) n++;
      end
      chk({p, "_noack"}, LW'(n), '0);
      req(s, {p, "_rd"}, 1'b0, 32'hA0, '0, '0, q, e);
      chk({p, "_data"}, q, {32{8'h3C}});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
